// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helper functions for the parameterised synchronous FIFO.
//   DATA_W_DEF : default data width in bits
//   DEPTH_DEF  : default entry count
//   count_w()  : width of an occupancy counter that can hold 0..depth
//   is_pow2()  : true when depth is a power of two
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 16;

   // Occupancy ranges over 0..depth inclusive, so one bit more than the pointer.
   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int depth);
      return (depth > 0) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x DATA_W storage with one write port and one synchronous read port.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the read data register only
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; loads rd_data from rd_addr on the same edge
//   rd_addr  : read address
//   rd_data  : registered read data, holds when rd_en is low
// A read and write to the same address on one edge returns the old contents.
// -----------------------------------------------------------------------------
module sync_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   // Array contents are never reset so the storage maps onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Output register with synchronous reset, matching the RAM output latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parameterised single-clock FIFO with occupancy count and status flags.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (priority over push/pop)
//   push         : write request, data_in sampled with it
//   pop          : read request
//   data_in      : write data
//   data_out     : registered read data, valid the cycle after an accepted pop
//   empty        : count == 0
//   full         : count == DEPTH
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : current occupancy
//   overflow     : one-cycle pulse after a rejected push
//   underflow    : one-cycle pulse after a rejected pop
// -----------------------------------------------------------------------------
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [DATA_W-1:0]         data_in,
   output logic [DATA_W-1:0]         data_out,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [count_w(DEPTH)-1:0] count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   // Elaboration-time parameter sanity checks.
   if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two, 2 or greater");
   end
   if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
      $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
   end

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic             underflow_reg, underflow_next;
   logic             push_ok;
   logic             pop_ok;

   // Flags depend on the registered count only: no input-to-output path.
   assign empty        = (count_reg == '0);
   assign full         = (count_reg == CNT_W'(DEPTH));
   assign almost_full  = (count_reg >= CNT_W'(AF_LEVEL));
   assign almost_empty = (count_reg <= CNT_W'(AE_LEVEL));
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

   // A pop frees a slot on the same edge, so a full FIFO still takes a push
   // when a pop is accepted alongside it.
   always_comb begin
      pop_ok         = pop && !empty;
      push_ok        = push && (!full || pop_ok);
      wr_ptr_next    = wr_ptr_reg;
      rd_ptr_next    = rd_ptr_reg;
      count_next     = count_reg;
      overflow_next  = push && !push_ok;
      underflow_next = pop && !pop_ok;

      if (push_ok) begin
         wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_next = count_reg + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   // When full, wr_ptr equals rd_ptr; the RAM returns the old word, so a
   // simultaneous push/pop yields the oldest entry.
   sync_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_ok && !rst),
      .wr_addr (wr_ptr_reg),
      .wr_data (data_in),
      .rd_en   (pop_ok && !rst),
      .rd_addr (rd_ptr_reg),
      .rd_data (data_out)
   );

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Table-driven bench for sync_fifo_param (DEPTH=4, AF=3, AE=1, DATA_W=32).
// Each table row is one clock: inputs plus the required count and pulse flags.
// A queue scoreboard supplies the expected data_out for every accepted pop.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int DW = 32;
   localparam int DP = 4;

   typedef struct {
      logic          push;
      logic          pop;
      logic [DW-1:0] data;
      logic [2:0]    exp_count;
      logic          exp_ovf;
      logic          exp_unf;
      string         name;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          push;
   logic          pop;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          empty, full, almost_full, almost_empty;
   logic [2:0]    count;
   logic          overflow, underflow;

   int            n_vec = 0;
   int            n_bad = 0;
   vec_t          tbl[$];
   logic [DW-1:0] sb[$];
   logic [DW-1:0] exp_dout;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .DATA_W   (DW),
      .DEPTH    (DP),
      .AF_LEVEL (3),
      .AE_LEVEL (1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .push         (push),
      .pop          (pop),
      .data_in      (data_in),
      .data_out     (data_out),
      .empty        (empty),
      .full         (full),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compare all outputs against a required count and pulse values.
   task automatic check_all(input string name, input logic [2:0] c, input logic ovf, input logic unf);
      check({name, ".count"}, DW'(count), DW'(c));
      check({name, ".empty"}, DW'(empty), DW'(c == 3'd0));
      check({name, ".full"}, DW'(full), DW'(c == 3'd4));
      check({name, ".almost_full"}, DW'(almost_full), DW'(c >= 3'd3));
      check({name, ".almost_empty"}, DW'(almost_empty), DW'(c <= 3'd1));
      check({name, ".overflow"}, DW'(overflow), DW'(ovf));
      check({name, ".underflow"}, DW'(underflow), DW'(unf));
      check({name, ".data_out"}, data_out, exp_dout);
   endtask

   function automatic vec_t mk(input logic pu, input logic po, input logic [DW-1:0] d,
                               input logic [2:0] c, input logic ovf, input logic unf,
                               input string name);
      vec_t v;
      v.push = pu; v.pop = po; v.data = d;
      v.exp_count = c; v.exp_ovf = ovf; v.exp_unf = unf; v.name = name;
      return v;
   endfunction

   // Drive one cycle and update the scoreboard from its own occupancy model.
   task automatic apply(input vec_t v);
      bit pop_acc, push_acc;
      pop_acc  = v.pop && (sb.size() > 0);
      push_acc = v.push && ((sb.size() < DP) || pop_acc);
      push     = v.push;
      pop      = v.pop;
      data_in  = v.data;
      @(posedge clk);
      #1;
      if (pop_acc) exp_dout = sb.pop_front();
      if (push_acc) sb.push_back(v.data);
      n_vec++;
      check_all(v.name, v.exp_count, v.exp_ovf, v.exp_unf);
      $display("vec %0d %s push=%0b pop=%0b din=%h dout=%h count=%0d ovf=%0b unf=%0b",
               n_vec, v.name, v.push, v.pop, v.data, data_out, count, overflow, underflow);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
      exp_dout = '0;

      // Underflow on an empty FIFO straight out of reset.
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 1, "unf_after_rst"));
      tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, "unf_clear"));
      // Ordered fill and drain.
      tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 0, "fill1"));
      tbl.push_back(mk(1, 0, 32'hCAFEBABE, 2, 0, 0, "fill2"));
      tbl.push_back(mk(1, 0, 32'hFEEDFACE, 3, 0, 0, "fill3"));
      tbl.push_back(mk(1, 0, 32'hBAADF00D, 4, 0, 0, "fill4"));
      tbl.push_back(mk(0, 1, 32'h0, 3, 0, 0, "drain1"));
      tbl.push_back(mk(0, 1, 32'h0, 2, 0, 0, "drain2"));
      tbl.push_back(mk(0, 1, 32'h0, 1, 0, 0, "drain3"));
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, "drain4"));
      // Overflow on a full FIFO, then simultaneous push/pop while full.
      tbl.push_back(mk(1, 0, 32'hDEADBEEF, 1, 0, 0, "refill1"));
      tbl.push_back(mk(1, 0, 32'hCAFEBABE, 2, 0, 0, "refill2"));
      tbl.push_back(mk(1, 0, 32'hFEEDFACE, 3, 0, 0, "refill3"));
      tbl.push_back(mk(1, 0, 32'hBAADF00D, 4, 0, 0, "refill4"));
      tbl.push_back(mk(1, 0, 32'h11111111, 4, 1, 0, "ovf_push"));
      tbl.push_back(mk(0, 0, 32'h0, 4, 0, 0, "ovf_clear"));
      tbl.push_back(mk(1, 1, 32'h22222222, 4, 0, 0, "full_pushpop"));
      tbl.push_back(mk(0, 1, 32'h0, 3, 0, 0, "post_pp1"));
      tbl.push_back(mk(0, 1, 32'h0, 2, 0, 0, "post_pp2"));
      tbl.push_back(mk(0, 1, 32'h0, 1, 0, 0, "post_pp3"));
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, "post_pp4"));
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 1, "unf_drained"));
      // Push and pop while empty: push only, no write-through.
      tbl.push_back(mk(1, 1, 32'h33333333, 1, 0, 1, "empty_pushpop"));
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, "empty_pp_pop"));
      // Ten values streamed at low occupancy so the pointers wrap repeatedly.
      tbl.push_back(mk(1, 0, 32'hA0000000, 1, 0, 0, "wrap_first"));
      for (int i = 1; i < 10; i++) begin
         tbl.push_back(mk(1, 1, 32'hA0000000 + DW'(i), 1, 0, 0, "wrap_pp"));
      end
      tbl.push_back(mk(0, 1, 32'h0, 0, 0, 0, "wrap_last"));

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      check_all("reset", 3'd0, 1'b0, 1'b0);
      $display("vec %0d reset count=%0d empty=%0b dout=%h", n_vec, count, empty, data_out);
      rst = 1'b0;

      foreach (tbl[i]) apply(tbl[i]);

      // Reset with push held while partially full discards everything.
      apply(mk(1, 0, 32'h55555551, 1, 0, 0, "pre_rst1"));
      apply(mk(1, 0, 32'h55555552, 2, 0, 0, "pre_rst2"));
      apply(mk(1, 0, 32'h55555553, 3, 0, 0, "pre_rst3"));
      rst = 1'b1; push = 1'b1; pop = 1'b0; data_in = 32'h66666666;
      @(posedge clk);
      #1;
      rst = 1'b0; push = 1'b0;
      sb.delete();
      exp_dout = '0;
      n_vec++;
      check_all("rst_push", 3'd0, 1'b0, 1'b0);
      $display("vec %0d rst_push count=%0d empty=%0b dout=%h", n_vec, count, empty, data_out);
      apply(mk(0, 1, 32'h0, 0, 0, 1, "post_rst_pop"));
      apply(mk(1, 0, 32'h44444444, 1, 0, 0, "post_rst_push"));
      apply(mk(0, 1, 32'h0, 0, 0, 0, "post_rst_drain"));
      check("post_rst_data", data_out, 32'h44444444);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
